// File: rtl/alu_mac_pkg.sv
// rtl/alu_mac_pkg.sv - opcodes, FSM encoding and width rule for alu_mac_unit
package alu_mac_pkg;

    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_SUB    = 3'b001;
    localparam logic [2:0] OP_AND    = 3'b010;
    localparam logic [2:0] OP_OR     = 3'b011;
    localparam logic [2:0] OP_XOR    = 3'b100;
    localparam logic [2:0] OP_MUL    = 3'b101;
    localparam logic [2:0] OP_MAC    = 3'b110;
    localparam logic [2:0] OP_CLRACC = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // The accumulator must hold a full product plus at least one carry bit.
    function automatic bit acc_width_ok(input int nbits, input int acc_w);
        return acc_w >= 2 * nbits + 1;
    endfunction

endpackage

// File: rtl/shift_add_mul.sv
// rtl/shift_add_mul.sv - iterative unsigned shift-add multiplier, one bit of b per cycle
module shift_add_mul #(
    parameter int NBITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [NBITS-1:0]     a,
    input  logic [NBITS-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*NBITS-1:0]   p
);

    localparam int CW = $clog2(NBITS + 1);

    logic [2*NBITS-1:0] mcand;
    logic [NBITS-1:0]   mplier;
    logic [CW-1:0]      cnt;

    // Bit 0 of b is consumed on the start edge, so done rises NBITS edges after start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            p      <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                p      <= b[0] ? {{NBITS{1'b0}}, a} : '0;
                mcand  <= {{NBITS{1'b0}}, a} << 1;
                mplier <= b >> 1;
                cnt    <= CW'(1);
                busy   <= (NBITS > 1);
                done   <= (NBITS == 1);
            end else if (busy) begin
                p      <= p + (mplier[0] ? mcand : '0);
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                if (cnt == CW'(NBITS - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_mac_unit.sv
// rtl/alu_mac_unit.sv - handshaked ALU with iterative multiplier and saturating accumulator
import alu_mac_pkg::*;

module alu_mac_unit #(
    parameter int NBITS = 8,
    parameter int ACC_W = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NBITS-1:0]   a,
    input  logic [NBITS-1:0]   b,
    input  logic [2:0]         opcode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   y,
    output logic               co
);

    generate
        if (!acc_width_ok(NBITS, ACC_W)) begin : g_width_check
            $error("alu_mac_unit: ACC_W must be at least 2*NBITS+1");
        end
    endgenerate

    state_t state, state_nxt;

    logic [2:0]         op_q;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   y_q;
    logic               co_q;

    logic               accept;
    logic               is_mult_in;
    logic               mul_busy;
    logic               mul_done;
    logic [2*NBITS-1:0] prod;

    logic [NBITS:0]     sum_ab;
    logic [NBITS:0]     diff_ab;
    logic [ACC_W-1:0]   alu_y;
    logic               alu_co;

    logic [ACC_W:0]     mac_sum;
    logic               mac_sat;
    logic [ACC_W-1:0]   mac_acc;

    assign accept     = in_valid && (state == IDLE);
    assign is_mult_in = (opcode == OP_MUL) || (opcode == OP_MAC);

    shift_add_mul #(.NBITS(NBITS)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept && is_mult_in),
        .a     (a),
        .b     (b),
        .busy  (mul_busy),
        .done  (mul_done),
        .p     (prod)
    );

    assign sum_ab  = {1'b0, a} + {1'b0, b};
    assign diff_ab = {1'b0, a} - {1'b0, b};

    always_comb begin
        alu_y  = '0;
        alu_co = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_y  = ACC_W'(sum_ab);
                alu_co = sum_ab[NBITS];
            end
            OP_SUB: begin
                alu_y  = ACC_W'(diff_ab[NBITS-1:0]);
                alu_co = diff_ab[NBITS];
            end
            OP_AND:  alu_y = ACC_W'(a & b);
            OP_OR:   alu_y = ACC_W'(a | b);
            OP_XOR:  alu_y = ACC_W'(a ^ b);
            default: alu_y = '0;
        endcase
    end

    // One extra bit on the sum exposes overflow past the accumulator ceiling.
    assign mac_sum = {1'b0, acc} + (ACC_W + 1)'(prod);
    assign mac_sat = mac_sum[ACC_W];
    assign mac_acc = mac_sat ? {ACC_W{1'b1}} : mac_sum[ACC_W-1:0];

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = is_mult_in ? BUSY : DONE;
            end
            BUSY: begin
                if (mul_done && !mul_busy) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            op_q  <= OP_ADD;
            acc   <= '0;
            y_q   <= '0;
            co_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q <= opcode;
                if (!is_mult_in) begin
                    y_q  <= alu_y;
                    co_q <= alu_co;
                end
                if (opcode == OP_CLRACC) acc <= '0;
            end
            if ((state == BUSY) && mul_done) begin
                if (op_q == OP_MAC) begin
                    acc  <= mac_acc;
                    y_q  <= mac_acc;
                    co_q <= mac_sat;
                end else begin
                    y_q  <= ACC_W'(prod);
                    co_q <= 1'b0;
                end
            end
        end
    end

    assign y  = y_q;
    assign co = co_q;

endmodule

// File: tb/tb_alu_mac_unit.sv
// tb/tb_alu_mac_unit.sv - self-checking bench for alu_mac_unit against an arithmetic reference model
import alu_mac_pkg::*;

module tb_alu_mac_unit;

    localparam int NBITS   = 8;
    localparam int ACC_W   = 20;
    localparam int ACC_MAX = (1 << ACC_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [NBITS-1:0] a;
    logic [NBITS-1:0] b;
    logic [2:0]       opcode;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] y;
    logic             co;

    int total = 0;
    int bad   = 0;
    int m_acc = 0;

    alu_mac_unit #(.NBITS(NBITS), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .co        (co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [2:0] op, input int ia, input int ib,
                                  output int ey, output int eco, output int elat);
        eco  = 0;
        elat = 1;
        ey   = 0;
        case (op)
            OP_ADD: begin ey = ia + ib; eco = (ey > 255) ? 1 : 0; end
            OP_SUB: begin ey = (ia - ib + 256) % 256; eco = (ia < ib) ? 1 : 0; end
            OP_AND: ey = ia & ib;
            OP_OR:  ey = ia | ib;
            OP_XOR: ey = ia ^ ib;
            OP_MUL: begin ey = ia * ib; elat = NBITS + 1; end
            OP_MAC: begin
                elat = NBITS + 1;
                if (m_acc + ia * ib > ACC_MAX) begin
                    m_acc = ACC_MAX;
                    eco   = 1;
                end else begin
                    m_acc = m_acc + ia * ib;
                end
                ey = m_acc;
            end
            default: begin m_acc = 0; ey = 0; end
        endcase
    endfunction

    // Entered and left at a falling edge; the inputs are scrambled right after acceptance.
    task automatic run_op(input string tag, input logic [2:0] op, input int ia, input int ib);
        int ey, eco, elat, lat, rdy_seen;
        model(op, ia, ib, ey, eco, elat);
        check({tag, "_in_ready"}, longint'(in_ready), 1);
        opcode    = op;
        a         = ia[NBITS-1:0];
        b         = ib[NBITS-1:0];
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        a        = NBITS'($urandom);
        b        = NBITS'($urandom);
        opcode   = 3'($urandom);
        lat      = 0;
        rdy_seen = 0;
        for (int i = 1; i <= 40; i++) begin
            if (out_valid) begin
                lat = i;
                break;
            end
            if (in_ready) rdy_seen++;
            @(negedge clk);
        end
        check({tag, "_latency"}, longint'(lat), longint'(elat));
        check({tag, "_y"}, longint'(y), longint'(ey));
        check({tag, "_co"}, longint'(co), longint'(eco));
        check({tag, "_busy_ready"}, longint'(rdy_seen + int'(in_ready)), 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int ey, eco, elat, got, pushed, last_t, seen;
        int exp_q[$];

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        opcode    = OP_ADD;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", longint'(in_ready), 1);
        check("reset_out_valid", longint'(out_valid), 0);
        check("reset_y", longint'(y), 0);
        check("reset_co", longint'(co), 0);

        run_op("add_200_100", OP_ADD, 200, 100);
        check("add_const_y", longint'(dut.y_q), 300);
        run_op("sub_5_10", OP_SUB, 5, 10);
        check("sub_const_y", longint'(y), 251);
        run_op("mul_255_255", OP_MUL, 255, 255);
        check("mul_const_y", longint'(y), 65025);

        run_op("clracc", OP_CLRACC, 0, 0);
        for (int k = 1; k <= 17; k++) begin
            run_op("mac_sat", OP_MAC, 255, 255);
            if (k == 16) check("mac16_y", longint'(y), 1040400);
            if (k == 17) begin
                check("mac17_y", longint'(y), ACC_MAX);
                check("mac17_co", longint'(co), 1);
            end
        end
        run_op("mac_zero_at_max", OP_MAC, 0, 0);
        check("mac_max_zero_y", longint'(y), ACC_MAX);
        check("mac_max_zero_co", longint'(co), 0);

        // Result held under back-pressure while a second request waits.
        model(OP_XOR, 8'hF0, 8'h3C, ey, eco, elat);
        opcode = OP_XOR; a = 8'hF0; b = 8'h3C; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        opcode = OP_ADD; a = 8'd1; b = 8'd2; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("hold_y", longint'(y), longint'(ey));
            check("hold_co", longint'(co), longint'(eco));
            check("hold_out_valid", longint'(out_valid), 1);
            check("hold_in_ready", longint'(in_ready), 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("hold_release_in_ready", longint'(in_ready), 1);
        check("hold_release_out_valid", longint'(out_valid), 0);
        @(negedge clk);
        in_valid = 1'b0;
        model(OP_ADD, 1, 2, ey, eco, elat);
        check("pending_out_valid", longint'(out_valid), 1);
        check("pending_y", longint'(y), longint'(ey));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset in the middle of a multiply clears acc and drops the result.
        run_op("clr_before_rst", OP_CLRACC, 0, 0);
        run_op("mac_10_10", OP_MAC, 10, 10);
        check("mac_10_10_acc", longint'(y), 100);
        opcode = OP_MUL; a = 8'd7; b = 8'd9; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        m_acc = 0;
        check("midrst_out_valid", longint'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_in_ready", longint'(in_ready), 1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        check("midrst_no_result", longint'(seen), 0);
        run_op("mac_after_rst", OP_MAC, 1, 1);
        check("mac_after_rst_y", longint'(y), 1);

        // Back-to-back ADDs with both handshakes held high.
        got = 0; pushed = 0; last_t = -1;
        opcode = OP_ADD; a = NBITS'($urandom); b = NBITS'($urandom);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int t = 0; t < 60 && got < 8; t++) begin
            if (out_valid) begin
                check("b2b_outstanding", longint'(exp_q.size()), 1);
                if (exp_q.size() > 0) check("b2b_y", longint'(y), longint'(exp_q.pop_front()));
                if (last_t >= 0) check("b2b_gap", longint'(t - last_t), 2);
                last_t = t;
                got++;
                a = NBITS'($urandom);
                b = NBITS'($urandom);
            end
            if (in_ready) begin
                if (pushed < 8) begin
                    exp_q.push_back(int'(a) + int'(b));
                    pushed++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_count", longint'(got), 8);
        @(negedge clk);

        for (int i = 0; i < 25; i++) begin
            run_op("random", 3'($urandom), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
